// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit limits, raw digit-sum width and the serial adder state encoding.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam int         BCD_SUM_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit binary adder: raw 5-bit sum {cout, v} plus the decimal-carry flag z.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic       cout,
    output logic [3:0] v,
    output logic       z
);

    logic [BCD_SUM_W-1:0] sum;

    // Invalid digits still add arithmetically; 15 + 15 + 1 = 31 always fits in five bits.
    assign sum  = {1'b0, a} + {1'b0, b} + {{(BCD_SUM_W-1){1'b0}}, cin};
    assign cout = sum[4];
    assign v    = sum[3:0];
    assign z    = (sum > {1'b0, BCD_MAX});

endmodule

// File: rtl/bcd_digit_serial_adder.sv
// Digit-serial BCD adder front end: one digit per step, LSD first, with a valid/ready
// digit output stream and a done pulse carrying the final decimal carry.
module bcd_digit_serial_adder
    import bcd_pkg::*;
#(
    parameter  int NDIGITS = 4,
    localparam int IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   a_bcd,
    input  logic [4*NDIGITS-1:0]   b_bcd,
    input  logic                   cin,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   digit_vld,
    output logic [IDX_W-1:0]       digit_idx,
    output logic                   cout,
    output logic [3:0]             v,
    output logic                   z,
    output logic                   done,
    output logic                   carry_out,
    output logic                   err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    state_t               state;
    state_t               next_state;
    logic [4*NDIGITS-1:0] a_sh;
    logic [4*NDIGITS-1:0] b_sh;
    logic                 carry_r;
    logic                 stepping;
    logic [IDX_W-1:0]     idx;
    logic                 sum_cout;
    logic [3:0]           sum_v;
    logic                 sum_z;
    logic                 step;
    logic                 accept;
    logic                 bad_digit;

    bcd_digit_add u_digit_add (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry_r),
        .cout (sum_cout),
        .v    (sum_v),
        .z    (sum_z)
    );

    // A new digit may be computed whenever the output slot is empty or being drained.
    assign accept = digit_vld && out_ready;
    assign step   = (state == RUN) && stepping && (!digit_vld || out_ready);
    assign busy   = (state != IDLE);

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (a_bcd[4*i +: 4] > BCD_MAX || b_bcd[4*i +: 4] > BCD_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (accept && !stepping) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // stepping drops after the last digit is computed; the FSM then only waits for its acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            carry_r   <= 1'b0;
            stepping  <= 1'b0;
            idx       <= '0;
            digit_vld <= 1'b0;
            digit_idx <= '0;
            cout      <= 1'b0;
            v         <= 4'd0;
            z         <= 1'b0;
            done      <= 1'b0;
            carry_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh      <= a_bcd;
                        b_sh      <= b_bcd;
                        carry_r   <= cin;
                        idx       <= '0;
                        stepping  <= 1'b1;
                        err       <= bad_digit;
                        carry_out <= 1'b0;
                    end
                end
                RUN: begin
                    if (step) begin
                        cout      <= sum_cout;
                        v         <= sum_v;
                        z         <= sum_z;
                        carry_r   <= sum_z;
                        digit_idx <= idx;
                        digit_vld <= 1'b1;
                        a_sh      <= a_sh >> 4;
                        b_sh      <= b_sh >> 4;
                        if (idx == LAST_IDX) begin
                            stepping <= 1'b0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (accept) begin
                        digit_vld <= 1'b0;
                        if (!stepping) begin
                            done      <= 1'b1;
                            carry_out <= carry_r;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_digit_serial_adder.sv
// Directed bench for bcd_digit_serial_adder: table of 4-digit sums plus reset and single-digit cases.
module tb_bcd_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a_bcd;
    logic [15:0] b_bcd;
    logic        cin;
    logic        out_ready;
    logic        busy;
    logic        digit_vld;
    logic [1:0]  digit_idx;
    logic        cout;
    logic [3:0]  v;
    logic        z;
    logic        done;
    logic        carry_out;
    logic        err;

    logic        start1;
    logic [3:0]  a1;
    logic [3:0]  b1;
    logic        cin1;
    logic        out_ready1;
    logic        busy1;
    logic        digit_vld1;
    logic [0:0]  digit_idx1;
    logic        cout1;
    logic [3:0]  v1;
    logic        z1;
    logic        done1;
    logic        carry_out1;
    logic        err1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [19:0] sums;
        logic        carry;
        logic        err;
        int          stall_idx;
        bit          inject;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    bcd_digit_serial_adder #(.NDIGITS(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_bcd     (a_bcd),
        .b_bcd     (b_bcd),
        .cin       (cin),
        .out_ready (out_ready),
        .busy      (busy),
        .digit_vld (digit_vld),
        .digit_idx (digit_idx),
        .cout      (cout),
        .v         (v),
        .z         (z),
        .done      (done),
        .carry_out (carry_out),
        .err       (err)
    );

    bcd_digit_serial_adder #(.NDIGITS(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .a_bcd     (a1),
        .b_bcd     (b1),
        .cin       (cin1),
        .out_ready (out_ready1),
        .busy      (busy1),
        .digit_vld (digit_vld1),
        .digit_idx (digit_idx1),
        .cout      (cout1),
        .v         (v1),
        .z         (z1),
        .done      (done1),
        .carry_out (carry_out1),
        .err       (err1)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one table entry; the stream is checked on every presented cycle, including stalls.
    task automatic apply_stimulus(input vec_t vv);
        int          count;
        int          stall_left;
        bit          seen_done;
        bit          injected;
        logic [4:0]  exp_sum;
        @(negedge clk);
        a_bcd = vv.a; b_bcd = vv.b; cin = vv.cin; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("busy_after_start", {31'd0, busy}, 32'd1);
        count = 0;
        stall_left = (vv.stall_idx >= 0) ? 3 : 0;
        seen_done = 1'b0;
        injected = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            a_bcd = vv.a;
            if (done) begin
                check_output("done_digit_count", count, 32'd4);
                check_output("carry_out", {31'd0, carry_out}, {31'd0, vv.carry});
                check_output("err_at_done", {31'd0, err}, {31'd0, vv.err});
                seen_done = 1'b1;
            end else if (digit_vld) begin
                if (count > 3) begin
                    check_output("extra_digit", count, 32'd3);
                    count = 3;
                end
                exp_sum = vv.sums[5*count +: 5];
                check_output("digit_idx", {30'd0, digit_idx}, count);
                check_output("digit_sum", {27'd0, cout, v}, {27'd0, exp_sum});
                check_output("digit_z", {31'd0, z}, {31'd0, (exp_sum > 5'd9)});
                check_output("err_in_run", {31'd0, err}, {31'd0, vv.err});
                if (stall_left > 0 && count == vv.stall_idx) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    count++;
                    if (vv.inject && count == 2 && !injected) begin
                        start = 1'b1;
                        a_bcd = 16'h9999;
                        injected = 1'b1;
                    end
                end
            end
        end
        if (!seen_done) check_output("done_timeout", 32'd0, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check_output("done_is_pulse", {31'd0, done}, 32'd0);
        check_output("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit seen;
        vecs[0] = '{16'h0999, 16'h0001, 1'b0, {5'd1, 5'd10, 5'd10, 5'd10}, 1'b0, 1'b0, -1, 1'b0};
        vecs[1] = '{16'h9999, 16'h9999, 1'b1, {5'd19, 5'd19, 5'd19, 5'd19}, 1'b1, 1'b0, -1, 1'b0};
        vecs[2] = '{16'h0999, 16'h0001, 1'b0, {5'd1, 5'd10, 5'd10, 5'd10}, 1'b0, 1'b0, 1, 1'b0};
        vecs[3] = '{16'h000C, 16'h0000, 1'b0, {5'd0, 5'd0, 5'd1, 5'd12}, 1'b0, 1'b1, -1, 1'b0};
        vecs[4] = '{16'h1234, 16'h5678, 1'b0, {5'd6, 5'd9, 5'd11, 5'd12}, 1'b0, 1'b0, -1, 1'b1};
        vecs[5] = '{16'h5000, 16'h5000, 1'b0, {5'd10, 5'd0, 5'd0, 5'd0}, 1'b1, 1'b0, 2, 1'b0};

        rst = 1'b1; start = 1'b0; a_bcd = '0; b_bcd = '0; cin = 1'b0; out_ready = 1'b1;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
        repeat (2) @(negedge clk);
        check_output("reset_outputs",
                     {22'd0, busy, digit_vld, digit_idx, cout, v, z, done, carry_out, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("post_reset_idle",
                     {22'd0, busy, digit_vld, digit_idx, cout, v, z, done, carry_out, err}, 32'd0);

        for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

        // Abort a running sum at digit 2: outputs clear at once and no done pulse may follow.
        @(negedge clk);
        a_bcd = 16'h0999; b_bcd = 16'h0001; cin = 1'b0; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            if (digit_vld && digit_idx == 2'd2) seen = 1'b1;
        end
        check_output("reached_digit2", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        #1;
        check_output("async_reset_clears",
                     {22'd0, busy, digit_vld, digit_idx, cout, v, z, done, carry_out, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check_output("no_done_after_reset", {31'd0, seen}, 32'd0);

        // Single-digit build: 5 + 4 + 1 = 10.
        @(negedge clk);
        a1 = 4'd5; b1 = 4'd4; cin1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (digit_vld1) seen = 1'b1;
        end
        check_output("n1_digit_seen", {31'd0, seen}, 32'd1);
        check_output("n1_digit", {25'd0, digit_idx1, cout1, v1, z1}, {25'd0, 1'b0, 5'd10, 1'b1});
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (done1) seen = 1'b1;
        end
        check_output("n1_done_seen", {31'd0, seen}, 32'd1);
        check_output("n1_carry_err", {30'd0, carry_out1, err1}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
